// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 memory access state encodings, bus gate selects and output decode.
package lc3_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LD_MAR = 3'd1;
  localparam logic [2:0] LD_MDR = 3'd2;
  localparam logic [2:0] ACCESS = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [1:0] GATE_NONE   = 2'b00;
  localparam logic [1:0] GATE_PC     = 2'b01;
  localparam logic [1:0] GATE_MARMUX = 2'b10;
  localparam logic [1:0] GATE_MDRSRC = 2'b11;

  typedef struct packed {
    logic       ldMAR;
    logic [1:0] gate_sel;
    logic       ldMDR;
    logic       mio_en;
    logic       r_w;
    logic       f_done;
    logic       d_done;
  } ctrl_out_t;

  // A load keeps ldMDR high for every ACCESS cycle; the last capture lands on the ready cycle.
  function automatic ctrl_out_t decode_out(input logic [2:0] st, input logic own_d,
                                           input logic store);
    ctrl_out_t o;
    o = '0;
    case (st)
      LD_MAR: begin
        o.ldMAR    = 1'b1;
        o.gate_sel = own_d ? GATE_MARMUX : GATE_PC;
      end
      LD_MDR: begin
        o.gate_sel = GATE_MDRSRC;
        o.ldMDR    = 1'b1;
      end
      ACCESS: begin
        o.mio_en = 1'b1;
        o.r_w    = store;
        o.ldMDR  = ~store;
      end
      DONE: begin
        o.f_done = ~own_d;
        o.d_done = own_d;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - requester/memory handshake bundle for mem_access_ctrl.
interface mem_access_ctrl_if;
  logic       f_req;
  logic       d_req;
  logic       d_we;
  logic       mem_ready;
  logic       ldMAR;
  logic [1:0] gate_sel;
  logic       ldMDR;
  logic       mio_en;
  logic       r_w;
  logic       f_done;
  logic       d_done;
  logic       err;

  modport master (
    output f_req, d_req, d_we, mem_ready,
    input  ldMAR, gate_sel, ldMDR, mio_en, r_w, f_done, d_done, err
  );

  modport slave (
    input  f_req, d_req, d_we, mem_ready,
    output ldMAR, gate_sel, ldMDR, mio_en, r_w, f_done, d_done, err
  );
endinterface

// File: rtl/mem_access_ctrl_rr_arb2.sv
// rtl/mem_access_ctrl_rr_arb2.sv - two-way round-robin arbiter (bit0 fetch, bit1 data).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_data,
  output logic [1:0] grant
);

  logic last_data;

  // Resetting to "data" makes the first contended grant go to fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   last_data <= 1'b1;
    else if (upd) last_data <= upd_data;
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last_data ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences MAR/MDR/memory for LC-3 fetch and data accesses.
module mem_access_ctrl
  import lc3_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         reset,
  mem_access_ctrl_if.slave bus
);

  logic [2:0]       state, state_nxt;
  logic             own_d, own_d_nxt;
  logic             store, store_nxt;
  logic [CNT_W-1:0] count;
  logic             timeout_hit;
  logic             err;
  logic [1:0]       grant;
  ctrl_out_t        out_q;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({bus.d_req, bus.f_req}),
    .upd      (state == DONE),
    .upd_data (own_d),
    .grant    (grant)
  );

  always_comb begin
    state_nxt   = state;
    own_d_nxt   = own_d;
    store_nxt   = store;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) begin
          state_nxt = LD_MAR;
          own_d_nxt = grant[1];
          store_nxt = grant[1] & bus.d_we;
        end
      end
      LD_MAR: state_nxt = store ? LD_MDR : ACCESS;
      LD_MDR: state_nxt = ACCESS;
      ACCESS: begin
        if (bus.mem_ready) begin
          state_nxt = DONE;
        end else if (count == CNT_W'(TIMEOUT - 1)) begin
          state_nxt   = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are flopped from the next-state decode so they track state with no input path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      own_d <= 1'b1;
      store <= 1'b0;
      count <= '0;
      err   <= 1'b0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      own_d <= own_d_nxt;
      store <= store_nxt;
      err   <= err | timeout_hit;
      out_q <= decode_out(state_nxt, own_d_nxt, store_nxt);
      if (state != ACCESS && state_nxt == ACCESS)
        count <= '0;
      else if (state == ACCESS && count != {CNT_W{1'b1}})
        count <= count + CNT_W'(1);
    end
  end

  assign bus.ldMAR    = out_q.ldMAR;
  assign bus.gate_sel = out_q.gate_sel;
  assign bus.ldMDR    = out_q.ldMDR;
  assign bus.mio_en   = out_q.mio_en;
  assign bus.r_w      = out_q.r_w;
  assign bus.f_done   = out_q.f_done;
  assign bus.d_done   = out_q.d_done;
  assign bus.err      = err;

endmodule
